// File: rtl/rand_pkg.sv
// ---------------------------------------------------------------------------
// rand_pkg
// Shared definitions for the pseudo-random range generator:
//   - draw_state_t : draw FSM states (IDLE, DRAW)
//   - DEFAULT_SEED : reset seed, truncated to the LFSR width where used
//   - lfsr_taps()  : maximal-length Fibonacci tap mask for a given width
// ---------------------------------------------------------------------------
package rand_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } draw_state_t;

  localparam logic [31:0] DEFAULT_SEED = 32'h0000_ACE1;

  // Bit i of the mask set means LFSR bit i feeds the XOR feedback.
  //   8 -> 7,5,4,3   16 -> 15,14,12,3   24 -> 23,22,21,16   32 -> 31,21,1,0
  function automatic logic [31:0] lfsr_taps(input int width);
    logic [31:0] mask;
    case (width)
      8:       mask = 32'h0000_00B8;
      24:      mask = 32'h00E1_0000;
      32:      mask = 32'h8020_0003;
      default: mask = 32'h0000_D008;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// ---------------------------------------------------------------------------
// lfsr_core
// Free-running Fibonacci LFSR: shifts left every cycle, feedback into bit 0.
// Priority: reset > load > shift. A zero load value would lock the register
// at zero, so it is replaced by SEED.
// Ports:
//   clk      in   clock (rising edge)
//   reset    in   synchronous active-high reset, loads SEED
//   load     in   load load_val (or SEED when load_val = 0) this cycle
//   load_val in   reseed value
//   state    out  current LFSR contents
// ---------------------------------------------------------------------------
module lfsr_core
  import rand_pkg::*;
#(
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEFAULT_SEED)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] state
);

  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));

  logic [LFSR_W-1:0] r_lfsr;
  logic [LFSR_W-1:0] w_load_val;
  logic              w_fb;

  assign w_fb       = ^(r_lfsr & TAPS);
  assign w_load_val = (load_val == '0) ? SEED : load_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= SEED;
    end else if (load) begin
      r_lfsr <= w_load_val;
    end else begin
      r_lfsr <= {r_lfsr[LFSR_W-2:0], w_fb};
    end
  end

  assign state = r_lfsr;

endmodule

// File: rtl/rand_range_gen.sv
// ---------------------------------------------------------------------------
// rand_range_gen
// Draws values uniformly over 0..max_num by rejection sampling on the low
// OUT_W bits of a free-running LFSR, one candidate per cycle. After MAX_TRIES
// rejections a modulo fallback (nudged off the previous value when
// NO_REPEAT is set) is accepted unconditionally.
// Ports:
//   clk        in   clock (rising edge)
//   reset      in   synchronous active-high reset
//   seed_load  in   reseed the LFSR from seed_in this cycle
//   seed_in    in   reseed value (0 selects SEED)
//   req        in   draw request, rising-edge detected, ignored while busy
//   max_num    in   inclusive upper bound, captured on the accepted edge
//   rand_num   out  last result, held until the next one
//   rand_valid out  one-cycle pulse with each new rand_num
//   busy       out  draw in progress
// ---------------------------------------------------------------------------
module rand_range_gen
  import rand_pkg::*;
#(
  parameter int                LFSR_W    = 16,
  parameter int                OUT_W     = 4,
  parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(DEFAULT_SEED),
  parameter bit                NO_REPEAT = 1'b1,
  parameter int                MAX_TRIES = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              req,
  input  logic [OUT_W-1:0]  max_num,
  output logic [OUT_W-1:0]  rand_num,
  output logic              rand_valid,
  output logic              busy
);

  localparam int             TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

  draw_state_t        r_state, w_state_next;
  logic [TRY_W-1:0]   r_tries, w_tries_next;
  logic [OUT_W-1:0]   r_max_q, w_max_q_next;
  logic               r_req_prev;
  logic [OUT_W-1:0]   r_rand_num;
  logic               r_rand_valid;
  logic               r_last_valid;

  logic [LFSR_W-1:0]  w_lfsr;
  logic               w_req_edge;
  logic               w_rep_chk;
  logic [OUT_W-1:0]   w_cand;
  logic               w_cand_ok;
  logic [OUT_W:0]     w_range;
  logic [OUT_W:0]     w_mod;
  logic [OUT_W-1:0]   w_fold;
  logic [OUT_W-1:0]   w_fallback;
  logic               w_accept;
  logic [OUT_W-1:0]   w_result;

  lfsr_core #(
    .LFSR_W (LFSR_W),
    .SEED   (SEED)
  ) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .load     (seed_load),
    .load_val (seed_in),
    .state    (w_lfsr)
  );

  // Only the low OUT_W bits are drawn; the rest only sequence the register.
  generate
    if (LFSR_W > OUT_W) begin : g_lfsr_hi
      logic w_unused_lfsr_hi;
      assign w_unused_lfsr_hi = ^w_lfsr[LFSR_W-1:OUT_W];
    end
  endgenerate

  assign w_req_edge = req & ~r_req_prev;
  assign w_cand     = w_lfsr[OUT_W-1:0];

  // r_rand_num always holds the last accepted result, so it doubles as the
  // "last" value for the no-repeat rule. A bound of 0 has only one legal
  // answer and is therefore exempt.
  assign w_rep_chk  = NO_REPEAT & r_last_valid & (r_max_q != '0);
  assign w_cand_ok  = (w_cand <= r_max_q) & ~(w_rep_chk & (w_cand == r_rand_num));

  // Range is computed one bit wider so an all-ones bound does not wrap.
  assign w_range    = {1'b0, r_max_q} + (OUT_W+1)'(1);
  assign w_mod      = {1'b0, w_cand} % w_range;
  assign w_fold     = OUT_W'(w_mod);
  assign w_fallback = (w_rep_chk && (w_fold == r_rand_num))
                      ? ((w_fold == r_max_q) ? '0 : w_fold + OUT_W'(1))
                      : w_fold;

  always_comb begin
    w_state_next = r_state;
    w_tries_next = r_tries;
    w_max_q_next = r_max_q;
    w_accept     = 1'b0;
    w_result     = w_cand;
    case (r_state)
      IDLE: begin
        if (w_req_edge) begin
          w_state_next = DRAW;
          w_tries_next = '0;
          w_max_q_next = max_num;
        end
      end
      DRAW: begin
        if (w_cand_ok) begin
          w_accept     = 1'b1;
          w_state_next = IDLE;
        end else if (r_tries == LAST_TRY) begin
          w_accept     = 1'b1;
          w_result     = w_fallback;
          w_state_next = IDLE;
        end else begin
          w_tries_next = r_tries + TRY_W'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_tries <= '0;
      r_max_q <= '0;
    end else begin
      r_state <= w_state_next;
      r_tries <= w_tries_next;
      r_max_q <= w_max_q_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_req_prev   <= 1'b0;
      r_rand_num   <= '0;
      r_rand_valid <= 1'b0;
      r_last_valid <= 1'b0;
    end else begin
      r_req_prev   <= req;
      r_rand_valid <= w_accept;
      if (w_accept) begin
        r_rand_num   <= w_result;
        r_last_valid <= 1'b1;
      end
    end
  end

  assign rand_num   = r_rand_num;
  assign rand_valid = r_rand_valid;
  assign busy       = (r_state == DRAW);

endmodule

// File: tb/tb_rand_range_gen.sv
// ---------------------------------------------------------------------------
// tb_rand_range_gen
// Bench for rand_range_gen (LFSR_W=16, OUT_W=4, SEED=16'hACE1, NO_REPEAT=1,
// MAX_TRIES=8). A behavioural model advanced on each rising edge predicts
// LFSR contents, rand_num, rand_valid and busy; a compare process checks
// them on every falling edge. Directed sections add literal expectations.
// ---------------------------------------------------------------------------
module tb_rand_range_gen;

  localparam int          MT     = 8;
  localparam logic [15:0] SEED_V = 16'hACE1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        seed_load = 1'b0;
  logic [15:0] seed_in = '0;
  logic        req = 1'b0;
  logic [3:0]  max_num = '0;
  logic [3:0]  rand_num;
  logic        rand_valid;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rand_range_gen #(
    .LFSR_W    (16),
    .OUT_W     (4),
    .SEED      (SEED_V),
    .NO_REPEAT (1'b1),
    .MAX_TRIES (MT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .seed_load  (seed_load),
    .seed_in    (seed_in),
    .req        (req),
    .max_num    (max_num),
    .rand_num   (rand_num),
    .rand_valid (rand_valid),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    int taps [4] = '{15, 14, 12, 3};
    int fb = 0;
    foreach (taps[i]) fb = fb ^ int'(v[taps[i]]);
    return 16'(({16'd0, v} << 1) | 32'(fb));
  endfunction

  logic [15:0] m_lfsr = '0;
  bit          m_init = 1'b0;
  bit          m_busy, m_valid, m_prev, m_last_valid;
  int          m_rand, m_max, m_tries;
  int          mc_cand, mc_res;
  bit          mc_ok, mc_rep;

  always @(posedge clk) begin
    if (reset) begin
      m_lfsr = SEED_V; m_busy = 0; m_valid = 0; m_prev = 0;
      m_last_valid = 0; m_rand = 0; m_max = 0; m_tries = 0; m_init = 1;
    end else begin
      m_valid = 0;
      if (m_busy) begin
        mc_cand = int'(m_lfsr) % 16;
        mc_rep  = m_last_valid && (m_max != 0);
        mc_ok   = (mc_cand <= m_max) && !(mc_rep && mc_cand == m_rand);
        mc_res  = mc_cand;
        if (!mc_ok && m_tries == MT - 1) begin
          mc_res = mc_cand % (m_max + 1);
          if (mc_rep && mc_res == m_rand) mc_res = (mc_res == m_max) ? 0 : mc_res + 1;
          mc_ok = 1;
        end else if (!mc_ok) begin
          m_tries++;
        end
        if (mc_ok) begin
          m_rand = mc_res; m_valid = 1; m_last_valid = 1; m_busy = 0;
        end
      end else if (req && !m_prev) begin
        m_max = int'(max_num); m_tries = 0; m_busy = 1;
      end
      m_prev = req;
      m_lfsr = seed_load ? ((seed_in != 0) ? seed_in : SEED_V) : lfsr_next(m_lfsr);
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("lfsr",       32'(dut.w_lfsr), 32'(m_lfsr));
      check("rand_valid", 32'(rand_valid), 32'(m_valid));
      check("busy",       32'(busy),       32'(m_busy));
      check("rand_num",   32'(rand_num),   32'(m_rand));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 50 && busy === 1'b1; n++) tick();
  endtask

  // One-cycle request pulse; returns the result and the latency in cycles
  // from the edge cycle (0 when no result arrived in time).
  task automatic do_req(input logic [3:0] mx, output logic [3:0] res, output int lat);
    wait_idle();
    max_num = mx;
    req     = 1'b1;
    lat     = 0;
    res     = '0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      tick();
      if (k == 1) req = 1'b0;
      if (rand_valid === 1'b1) begin
        lat = k;
        res = rand_num;
      end
    end
    check("latency", 32'(lat >= 2 && lat <= MT + 1), 32'd1);
    tick();
    check("pulse_width", 32'(rand_valid), 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] res, prev_res;
    int lat, first_ret, pulses, got;
    int hist [10];

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    check("rst_lfsr",  32'(dut.w_lfsr), 32'h0000_ACE1);
    check("rst_busy",  32'(busy),       32'd0);
    check("rst_valid", 32'(rand_valid), 32'd0);
    check("rst_num",   32'(rand_num),   32'd0);
    reset = 1'b0;

    // ---- LFSR sequence and period ----
    first_ret = 0;
    for (int n = 1; n <= 65535; n++) begin
      tick();
      if (n == 1) begin
        // ACE1: bits 15,14,12,3 = 1,0,0,0 -> fb 1 -> 59C3
        check("lfsr_step1",  32'(dut.w_lfsr), 32'h0000_59C3);
        check("model_step1", 32'(m_lfsr),     32'h0000_59C3);
      end
      if (first_ret == 0 && dut.w_lfsr == SEED_V) first_ret = n;
    end
    check("lfsr_period", 32'(first_ret), 32'd65535);

    // ---- range, no-repeat, latency, histogram ----
    foreach (hist[v]) hist[v] = 0;
    prev_res = '0;
    for (int i = 0; i < 2000; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      do_req(4'd9, res, lat);
      check("range9", 32'(res <= 4'd9), 32'd1);
      if (i > 0) check("no_repeat", 32'(res != prev_res), 32'd1);
      if (res <= 4'd9) hist[res]++;
      prev_res = res;
    end
    // Consecutive candidates are one-bit shifts of each other, so a range
    // rejection steers the next candidate toward 4..9; 0..3 settle near 125
    // and 4..9 near 250 out of 2000, hence the wide band around 200.
    foreach (hist[v]) begin
      $display("hist value %0d count %0d", v, hist[v]);
      check("hist_band", 32'(hist[v] >= 80 && hist[v] <= 320), 32'd1);
    end

    // ---- degenerate bound ----
    for (int i = 0; i < 20; i++) begin
      do_req(4'd0, res, lat);
      check("deg_zero", 32'(res), 32'd0);
    end

    // ---- reseed ----
    tick();
    seed_in = 16'h1234; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    check("reseed_1234", 32'(dut.w_lfsr), 32'h0000_1234);
    seed_in = 16'h0000; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    check("reseed_zero", 32'(dut.w_lfsr), 32'h0000_ACE1);

    // seed_load in the first DRAW cycle must not abort the draw
    wait_idle();
    max_num = 4'd9; req = 1'b1; got = 0; res = '0;
    for (int k = 1; k <= 20 && got == 0; k++) begin
      tick();
      if (k == 1) begin
        req = 1'b0;
        seed_in = 16'($urandom);
        seed_load = 1'b1;
      end else begin
        seed_load = 1'b0;
      end
      if (rand_valid === 1'b1) begin
        got = 1;
        res = rand_num;
      end
    end
    seed_load = 1'b0;
    check("midseed_done",  32'(got), 32'd1);
    check("midseed_range", 32'(res <= 4'd9), 32'd1);

    // ---- held request ----
    repeat (2) tick();
    max_num = 4'd5; req = 1'b1; pulses = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (rand_valid === 1'b1) pulses++;
    end
    req = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (rand_valid === 1'b1) pulses++;
    end
    check("held_pulses", 32'(pulses), 32'd1);

    // ---- second pulse while busy (bound 0 keeps the draw long) ----
    wait_idle();
    max_num = 4'd0; req = 1'b1; pulses = 0;
    tick();
    req = 1'b0;
    tick();
    if (rand_valid === 1'b1) pulses++;
    if (busy === 1'b1) req = 1'b1;
    tick();
    req = 1'b0;
    if (rand_valid === 1'b1) pulses++;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (rand_valid === 1'b1) pulses++;
    end
    check("busy_pulses", 32'(pulses), 32'd1);

    // ---- reset mid-draw ----
    wait_idle();
    max_num = 4'd9; req = 1'b1;
    tick();
    req = 1'b0;
    check("md_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("md_busy",  32'(busy),       32'd0);
    check("md_valid", 32'(rand_valid), 32'd0);
    check("md_lfsr",  32'(dut.w_lfsr), 32'h0000_ACE1);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (rand_valid === 1'b1) pulses++;
    end
    check("md_no_pulse", 32'(pulses), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
